// File: rtl/fsb_axil_pkt_bridge_if.sv
// AXI-Lite host-side bus of the FSB packet bridge (32-bit data, single outstanding
// transaction per direction). The host drives the master modport; the bridge takes the slave.
interface fsb_axil_pkt_bridge_if;
  logic        s_awvalid;
  logic [31:0] s_awaddr;
  logic        s_awready;
  logic        s_wvalid;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wready;
  logic        s_bvalid;
  logic [1:0]  s_bresp;
  logic        s_bready;
  logic        s_arvalid;
  logic [31:0] s_araddr;
  logic        s_arready;
  logic        s_rvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rready;

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    output s_arvalid, s_araddr, s_rready,
    input  s_awready, s_wready, s_bvalid, s_bresp,
    input  s_arready, s_rvalid, s_rdata, s_rresp
  );

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    input  s_arvalid, s_araddr, s_rready,
    output s_awready, s_wready, s_bvalid, s_bresp,
    output s_arready, s_rvalid, s_rdata, s_rresp
  );
endinterface

// File: rtl/fsb_axil_pkt_bridge.sv
// AXI-Lite slave that assembles host writes into FSB packets (TX FIFO) and lets the
// host drain FSB packets (RX FIFO) through three-word register windows.
module fsb_axil_pkt_bridge #(
  parameter int tx_els_p    = 16,
  parameter int rx_els_p    = 16,
  parameter int fsb_width_p = 80
) (
  input  logic                   clk,
  input  logic                   pipe_rst_n,
  fsb_axil_pkt_bridge_if.slave   axil,
  output logic                   fsb_v_o,
  output logic [fsb_width_p-1:0] fsb_data_o,
  input  logic                   fsb_ready_i,
  input  logic                   fsb_v_i,
  input  logic [fsb_width_p-1:0] fsb_data_i,
  output logic                   fsb_ready_o
);
  localparam int tx_ptr_w_lp = $clog2(tx_els_p);
  localparam int tx_cnt_w_lp = tx_ptr_w_lp + 1;
  localparam int rx_ptr_w_lp = $clog2(rx_els_p);
  localparam int rx_cnt_w_lp = rx_ptr_w_lp + 1;
  localparam int hi_w_lp     = fsb_width_p - 64;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e                r_w_state;
  r_state_e                r_r_state;
  logic                    r_live;
  logic                    r_bvalid;
  logic                    r_arready;
  logic                    r_rvalid;
  logic [31:0]             r_rdata;
  logic [31:0]             r_tx0;
  logic [31:0]             r_tx1;
  logic                    r_tx_ovf;
  logic                    r_rx_udf;

  logic [fsb_width_p-1:0]  r_tx_mem [tx_els_p];
  logic [tx_ptr_w_lp-1:0]  r_tx_wr;
  logic [tx_ptr_w_lp-1:0]  r_tx_rd;
  logic [tx_cnt_w_lp-1:0]  r_tx_cnt;
  logic                    r_tx_v;

  logic [fsb_width_p-1:0]  r_rx_mem [rx_els_p];
  logic [rx_ptr_w_lp-1:0]  r_rx_wr;
  logic [rx_ptr_w_lp-1:0]  r_rx_rd;
  logic [rx_cnt_w_lp-1:0]  r_rx_cnt;
  logic                    r_rx_ready;

  logic                    w_wr_hs;
  logic                    w_rd_hs;
  logic [3:0]              w_wr_idx;
  logic [3:0]              w_rd_idx;
  logic                    w_tx_full;
  logic                    w_tx_push;
  logic                    w_tx_pop;
  logic [tx_cnt_w_lp-1:0]  w_tx_cnt_nxt;
  logic [tx_cnt_w_lp-1:0]  w_tx_vac;
  logic                    w_rx_empty;
  logic                    w_rx_push;
  logic                    w_rx_pop;
  logic [rx_cnt_w_lp-1:0]  w_rx_cnt_nxt;
  logic [fsb_width_p-1:0]  w_rx_head;
  logic                    w_sts_wr;
  logic                    w_tx_ovf_set;
  logic                    w_rx_udf_set;
  logic [31:0]             w_rd_data;
  logic                    w_unused_ok;

  // Write address/data are taken together in one cycle; r_live masks the cycle leaving reset.
  assign w_wr_hs   = r_live & (r_w_state == W_IDLE) & axil.s_awvalid & axil.s_wvalid;
  assign w_rd_hs   = r_arready & axil.s_arvalid;
  assign w_wr_idx  = axil.s_awaddr[5:2];
  assign w_rd_idx  = axil.s_araddr[5:2];

  assign w_tx_full    = (r_tx_cnt == tx_cnt_w_lp'(tx_els_p));
  assign w_tx_push    = w_wr_hs & (w_wr_idx == 4'd2) & ~w_tx_full;
  assign w_tx_pop     = r_tx_v & fsb_ready_i;
  assign w_tx_cnt_nxt = r_tx_cnt + tx_cnt_w_lp'(w_tx_push) - tx_cnt_w_lp'(w_tx_pop);
  assign w_tx_vac     = tx_cnt_w_lp'(tx_els_p) - r_tx_cnt;

  assign w_rx_empty   = (r_rx_cnt == {rx_cnt_w_lp{1'b0}});
  assign w_rx_push    = fsb_v_i & r_rx_ready;
  assign w_rx_pop     = w_rd_hs & (w_rd_idx == 4'd5) & ~w_rx_empty;
  assign w_rx_cnt_nxt = r_rx_cnt + rx_cnt_w_lp'(w_rx_push) - rx_cnt_w_lp'(w_rx_pop);
  assign w_rx_head    = r_rx_mem[r_rx_rd];

  assign w_sts_wr     = w_wr_hs & (w_wr_idx == 4'd8);
  assign w_tx_ovf_set = w_wr_hs & (w_wr_idx == 4'd2) & w_tx_full;
  assign w_rx_udf_set = w_rd_hs & (w_rd_idx == 4'd5) & w_rx_empty;

  assign axil.s_awready = w_wr_hs;
  assign axil.s_wready  = w_wr_hs;
  assign axil.s_bvalid  = r_bvalid;
  assign axil.s_bresp   = 2'b00;
  assign axil.s_arready = r_arready;
  assign axil.s_rvalid  = r_rvalid;
  assign axil.s_rdata   = r_rdata;
  assign axil.s_rresp   = 2'b00;

  assign fsb_v_o     = r_tx_v;
  assign fsb_data_o  = r_tx_v ? r_tx_mem[r_tx_rd] : {fsb_width_p{1'b0}};
  assign fsb_ready_o = r_rx_ready;

  assign w_unused_ok = ^{axil.s_awaddr[31:6], axil.s_awaddr[1:0], axil.s_araddr[31:6],
                         axil.s_araddr[1:0], axil.s_wstrb};

  // Read-data selection from pre-cycle FIFO and status state.
  always_comb begin
    w_rd_data = 32'h0000_0000;
    case (w_rd_idx)
      4'd3:    w_rd_data = w_rx_empty ? 32'h0000_0000 : w_rx_head[31:0];
      4'd4:    w_rd_data = w_rx_empty ? 32'h0000_0000 : w_rx_head[63:32];
      4'd5:    w_rd_data = w_rx_empty ? 32'h0000_0000 : 32'(w_rx_head[fsb_width_p-1:64]);
      4'd6:    w_rd_data = 32'(w_tx_vac);
      4'd7:    w_rd_data = 32'(r_rx_cnt);
      4'd8:    w_rd_data = {30'd0, r_rx_udf, r_tx_ovf};
      default: w_rd_data = 32'h0000_0000;
    endcase
  end

  // Write FSM: one-cycle accept, then hold the response until the host takes it.
  always_ff @(posedge clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n) begin
      r_w_state <= W_IDLE;
      r_bvalid  <= 1'b0;
    end else begin
      case (r_w_state)
        W_IDLE: begin
          if (w_wr_hs) begin
            r_w_state <= W_RESP;
            r_bvalid  <= 1'b1;
          end
        end
        W_RESP: begin
          if (axil.s_bready) begin
            r_w_state <= W_IDLE;
            r_bvalid  <= 1'b0;
          end
        end
        default: begin
          r_w_state <= W_IDLE;
          r_bvalid  <= 1'b0;
        end
      endcase
    end
  end

  // Read FSM: capture data on the ar handshake and hold it until rready.
  always_ff @(posedge clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n) begin
      r_r_state <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'h0000_0000;
    end else begin
      case (r_r_state)
        R_IDLE: begin
          if (w_rd_hs) begin
            r_r_state <= R_DATA;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_data;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (axil.s_rready) begin
            r_r_state <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
          end
        end
        default: begin
          r_r_state <= R_IDLE;
          r_arready <= 1'b0;
          r_rvalid  <= 1'b0;
        end
      endcase
    end
  end

  // Staging words, sticky status and FIFO bookkeeping.
  always_ff @(posedge clk or negedge pipe_rst_n) begin
    if (!pipe_rst_n) begin
      r_live     <= 1'b0;
      r_tx0      <= 32'h0000_0000;
      r_tx1      <= 32'h0000_0000;
      r_tx_ovf   <= 1'b0;
      r_rx_udf   <= 1'b0;
      r_tx_wr    <= {tx_ptr_w_lp{1'b0}};
      r_tx_rd    <= {tx_ptr_w_lp{1'b0}};
      r_tx_cnt   <= {tx_cnt_w_lp{1'b0}};
      r_tx_v     <= 1'b0;
      r_rx_wr    <= {rx_ptr_w_lp{1'b0}};
      r_rx_rd    <= {rx_ptr_w_lp{1'b0}};
      r_rx_cnt   <= {rx_cnt_w_lp{1'b0}};
      r_rx_ready <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_wr_hs && (w_wr_idx == 4'd0)) r_tx0 <= axil.s_wdata;
      if (w_wr_hs && (w_wr_idx == 4'd1)) r_tx1 <= axil.s_wdata;
      // A set in the same cycle as a W1C wins, so no event is lost.
      r_tx_ovf <= w_tx_ovf_set | (r_tx_ovf & ~(w_sts_wr & axil.s_wdata[0]));
      r_rx_udf <= w_rx_udf_set | (r_rx_udf & ~(w_sts_wr & axil.s_wdata[1]));
      if (w_tx_push) r_tx_wr <= r_tx_wr + tx_ptr_w_lp'(1'b1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + tx_ptr_w_lp'(1'b1);
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_v     <= (w_tx_cnt_nxt != {tx_cnt_w_lp{1'b0}});
      if (w_rx_push) r_rx_wr <= r_rx_wr + rx_ptr_w_lp'(1'b1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + rx_ptr_w_lp'(1'b1);
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_ready <= (w_rx_cnt_nxt != rx_cnt_w_lp'(rx_els_p));
    end
  end

  // FIFO storage; contents are only meaningful behind the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= {axil.s_wdata[hi_w_lp-1:0], r_tx1, r_tx0};
    if (w_rx_push) r_rx_mem[r_rx_wr] <= fsb_data_i;
  end
endmodule

// File: tb/tb_fsb_axil_pkt_bridge.sv
// Scoreboard bench for fsb_axil_pkt_bridge: stimulus queues expected read data and TX
// packets, a negedge monitor compares them as the DUT presents them.
module tb_fsb_axil_pkt_bridge;
  logic        clk = 1'b0;
  logic        pipe_rst_n;
  logic        fsb_v_o;
  logic [79:0] fsb_data_o;
  logic        fsb_ready_i;
  logic        fsb_v_i;
  logic [79:0] fsb_data_i;
  logic        fsb_ready_o;

  typedef struct {
    string       nm;
    logic [31:0] val;
  } rd_exp_t;

  rd_exp_t     exp_rd_q [$];
  logic [79:0] exp_tx_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  fsb_axil_pkt_bridge_if axil ();

  fsb_axil_pkt_bridge dut (
    .clk         (clk),
    .pipe_rst_n  (pipe_rst_n),
    .axil        (axil),
    .fsb_v_o     (fsb_v_o),
    .fsb_data_o  (fsb_data_o),
    .fsb_ready_i (fsb_ready_i),
    .fsb_v_i     (fsb_v_i),
    .fsb_data_i  (fsb_data_i),
    .fsb_ready_o (fsb_ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compare every accepted read beat and every FSB TX transfer.
  always @(negedge clk) begin
    if (pipe_rst_n) begin
      if (axil.s_rvalid && axil.s_rready) begin
        if (exp_rd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_unexpected: got %0h expected none", axil.s_rdata);
        end else begin
          rd_exp_t e;
          e = exp_rd_q.pop_front();
          check(e.nm, {64'd0, axil.s_rdata}, {64'd0, e.val});
          check("rresp", {94'd0, axil.s_rresp}, 96'd0);
        end
      end
      if (axil.s_bvalid && axil.s_bready)
        check("bresp", {94'd0, axil.s_bresp}, 96'd0);
      if (fsb_v_o && fsb_ready_i) begin
        if (exp_tx_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_unexpected: got %0h expected none", fsb_data_o);
        end else begin
          logic [79:0] et;
          et = exp_tx_q.pop_front();
          check("tx_pkt", {16'd0, fsb_data_o}, {16'd0, et});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d);
    int t;
    axil.s_awaddr  = a;
    axil.s_wdata   = d;
    axil.s_awvalid = 1'b1;
    axil.s_wvalid  = 1'b1;
    t = 0;
    @(negedge clk);
    while (!axil.s_awready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL wr_timeout: got no awready expected awready at addr %0h", a);
    end
    step();
    axil.s_awvalid = 1'b0;
    axil.s_wvalid  = 1'b0;
    check("bvalid_latency", {95'd0, axil.s_bvalid}, 96'd1);
    step();
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] e, input string nm);
    int      t;
    rd_exp_t x;
    x.nm  = nm;
    x.val = e;
    exp_rd_q.push_back(x);
    axil.s_araddr  = a;
    axil.s_arvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!axil.s_arready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_ar_timeout: got no arready expected arready", nm);
    end
    step();
    axil.s_arvalid = 1'b0;
    t = 0;
    while (exp_rd_q.size() != 0 && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_r_timeout: got no rvalid expected rvalid", nm);
      exp_rd_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pipe_rst_n     = 1'b0;
    axil.s_awvalid = 1'b0;
    axil.s_awaddr  = 32'h0;
    axil.s_wvalid  = 1'b0;
    axil.s_wdata   = 32'h0;
    axil.s_wstrb   = 4'hF;
    axil.s_bready  = 1'b1;
    axil.s_arvalid = 1'b0;
    axil.s_araddr  = 32'h0;
    axil.s_rready  = 1'b1;
    fsb_ready_i    = 1'b0;
    fsb_v_i        = 1'b0;
    fsb_data_i     = 80'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", {95'd0, axil.s_awready}, 96'd0);
    check("rst_bvalid",  {95'd0, axil.s_bvalid},  96'd0);
    check("rst_arready", {95'd0, axil.s_arready}, 96'd0);
    check("rst_rvalid",  {95'd0, axil.s_rvalid},  96'd0);
    check("rst_rdata",   {64'd0, axil.s_rdata},   96'd0);
    check("rst_fsb_v_o", {95'd0, fsb_v_o},        96'd0);
    @(negedge clk);
    pipe_rst_n = 1'b1;
    step();
    check("post_rst_fsb_ready_o", {95'd0, fsb_ready_o}, 96'd1);
    axi_read(32'h18, 32'd16, "tx_vac_reset");
    axi_read(32'h1C, 32'd0,  "rx_occ_reset");
    axi_read(32'h20, 32'd0,  "status_reset");
    axi_read(32'h24, 32'd0,  "unmapped_read");

    // Single TX packet assembly
    axi_write(32'h00, 32'h1111_2222);
    axi_write(32'h04, 32'h3333_4444);
    axi_write(32'h08, 32'h0000_5566);
    check("tx_v_after_push", {95'd0, fsb_v_o}, 96'd1);
    check("tx_head", {16'd0, fsb_data_o}, {16'd0, 80'h5566_3333_4444_1111_2222});
    exp_tx_q.push_back(80'h5566_3333_4444_1111_2222);
    fsb_ready_i = 1'b1;
    step();
    fsb_ready_i = 1'b0;
    check("tx_v_after_pop", {95'd0, fsb_v_o}, 96'd0);

    // TX overflow: 17 pushes into a 16-deep FIFO; TX1 staging still 0x33334444
    for (int i = 0; i < 17; i++) begin
      axi_write(32'h00, 32'hA000_0000 | 32'(i));
      axi_write(32'h08, 32'(i));
      if (i < 16) exp_tx_q.push_back({16'(i), 32'h3333_4444, 32'hA000_0000 | 32'(i)});
    end
    axi_read(32'h18, 32'd0, "tx_vac_full");
    axi_read(32'h20, 32'd1, "status_tx_ovf");
    fsb_ready_i = 1'b1;
    repeat (20) step();
    fsb_ready_i = 1'b0;
    check("tx_drain_count", {64'd0, 32'(exp_tx_q.size())}, 96'd0);
    check("tx_v_drained", {95'd0, fsb_v_o}, 96'd0);
    axi_write(32'h20, 32'h0000_0001);
    axi_read(32'h20, 32'd0,  "status_cleared");
    axi_read(32'h18, 32'd16, "tx_vac_empty");

    // Single RX packet
    fsb_data_i = 80'hABCD_0123_4567_89AB_CDEF;
    fsb_v_i    = 1'b1;
    step();
    fsb_v_i    = 1'b0;
    axi_read(32'h1C, 32'd1,          "rx_occ_one");
    axi_read(32'h0C, 32'h89AB_CDEF,  "rx0");
    axi_read(32'h10, 32'h0123_4567,  "rx1");
    axi_read(32'h14, 32'h0000_ABCD,  "rx2_pop");
    axi_read(32'h1C, 32'd0,          "rx_occ_zero");

    // RX underflow, then fill to full
    axi_read(32'h0C, 32'd0, "rx0_empty");
    axi_read(32'h20, 32'd0, "status_no_flag_rx0");
    axi_read(32'h14, 32'd0, "rx2_empty");
    axi_read(32'h20, 32'd2, "status_rx_udf");
    for (int i = 0; i < 16; i++) begin
      fsb_data_i = {16'hC000 | 16'(i), 32'(i), 32'hF000_0000 | 32'(i)};
      fsb_v_i    = 1'b1;
      step();
    end
    check("rx_full_ready", {95'd0, fsb_ready_o}, 96'd0);
    fsb_data_i = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    step();
    fsb_v_i = 1'b0;
    axi_read(32'h1C, 32'd16,          "rx_occ_full");
    axi_read(32'h14, 32'h0000_C000,   "rx2_pkt0");
    check("rx_ready_after_pop", {95'd0, fsb_ready_o}, 96'd1);
    axi_read(32'h0C, 32'hF000_0001,   "rx0_pkt1");
    axi_read(32'h1C, 32'd15,          "rx_occ_15");
    axi_write(32'h20, 32'h0000_0002);
    axi_read(32'h20, 32'd0,           "status_udf_cleared");

    // Stalled responses, then reset in the middle of the stall
    axi_write(32'h08, 32'h0000_1234);
    check("tx_v_before_stall", {95'd0, fsb_v_o}, 96'd1);
    axil.s_bready  = 1'b0;
    axil.s_rready  = 1'b0;
    axil.s_awaddr  = 32'h00;
    axil.s_wdata   = 32'h0000_DEAD;
    axil.s_awvalid = 1'b1;
    axil.s_wvalid  = 1'b1;
    axil.s_araddr  = 32'h1C;
    axil.s_arvalid = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_bvalid",  {95'd0, axil.s_bvalid},  96'd1);
      check("hold_rvalid",  {95'd0, axil.s_rvalid},  96'd1);
      check("hold_rdata",   {64'd0, axil.s_rdata},   96'd15);
      check("hold_awready", {95'd0, axil.s_awready}, 96'd0);
      check("hold_arready", {95'd0, axil.s_arready}, 96'd0);
    end
    step();
    pipe_rst_n = 1'b0;
    #1;
    check("async_rst_bvalid", {95'd0, axil.s_bvalid}, 96'd0);
    check("async_rst_rvalid", {95'd0, axil.s_rvalid}, 96'd0);
    check("async_rst_fsb_v",  {95'd0, fsb_v_o},       96'd0);
    axil.s_awvalid = 1'b0;
    axil.s_wvalid  = 1'b0;
    axil.s_arvalid = 1'b0;
    axil.s_bready  = 1'b1;
    axil.s_rready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    pipe_rst_n = 1'b1;
    step();
    axi_read(32'h1C, 32'd0,  "rx_occ_after_rst");
    axi_read(32'h18, 32'd16, "tx_vac_after_rst");
    axi_read(32'h20, 32'd0,  "status_after_rst");
    check("fsb_v_after_rst", {95'd0, fsb_v_o}, 96'd0);

    step();
    check("rd_queue_empty", {64'd0, 32'(exp_rd_q.size())}, 96'd0);
    check("tx_queue_empty", {64'd0, 32'(exp_tx_q.size())}, 96'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fsb_axil_pkt_bridge.md
Name: fsb_axil_pkt_bridge

Overview:
AXI-Lite slave that lets the host exchange 80-bit FSB packets through 32-bit register accesses. It sits on one slot of the OCL AXI-Lite mux and connects to an FSB node through valid/ready channels. Host writes are assembled into packets and queued in a TX FIFO toward the FSB. Packets arriving from the FSB are queued in an RX FIFO and drained by host reads. Occupancy and sticky error status are readable by the host.

Parameters:
tx_els_p, 16, TX FIFO depth in packets (power of 2, ≥2)
rx_els_p, 16, RX FIFO depth in packets (power of 2, ≥2)
fsb_width_p, 80, FSB packet width (fixed 80; 65..96 legal)

Ports:
clk  in  1  clock
pipe_rst_n  in  1  reset, asynchronous, active-low
s_awvalid  in  1  AXI-Lite write address valid
s_awaddr  in  32  write address; only [5:2] decoded
s_awready  out  1  write address ready
s_wvalid  in  1  write data valid
s_wdata  in  32  write data
s_wstrb  in  4  ignored; writes are full-word
s_wready  out  1  write data ready
s_bvalid  out  1  write response valid
s_bresp  out  2  always 2'b00
s_bready  in  1  write response ready
s_arvalid  in  1  read address valid
s_araddr  in  32  read address; only [5:2] decoded
s_arready  out  1  read address ready
s_rvalid  out  1  read data valid
s_rdata  out  32  read data
s_rresp  out  2  always 2'b00
s_rready  in  1  read data ready
fsb_v_o  out  1  TX packet valid (TX FIFO not empty)
fsb_data_o  out  fsb_width_p  TX head packet
fsb_ready_i  in  1  FSB accepts TX packet when fsb_v_o & fsb_ready_i
fsb_v_i  in  1  RX packet valid
fsb_data_i  in  fsb_width_p  RX packet
fsb_ready_o  out  1  RX FIFO not full

Behaviour:
- Reset: async assert, sync deassert. Outputs go to 0: s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata, fsb_v_o. FIFOs empty, staging registers and sticky bits cleared. fsb_ready_o=1 one cycle after deassertion. Reset mid-transaction drops in-flight responses and FIFO contents.
- Register map (byte offsets):
  - 0x00 TX0 W, packet[31:0]
  - 0x04 TX1 W, packet[63:32]
  - 0x08 TX2 W, packet[79:64] from wdata[15:0]; the write pushes {TX2,TX1,TX0}
  - 0x0C RX0 R, head[31:0]
  - 0x10 RX1 R, head[63:32]
  - 0x14 RX2 R, {16'b0, head[79:64]}; the read pops
  - 0x18 TX_VAC R, free TX entries
  - 0x1C RX_OCC R, RX entries
  - 0x20 STATUS R/W1C, bit0 tx_overflow, bit1 rx_underflow
  - Unmapped reads return 0; unmapped writes are ignored. All responses are OKAY.
- Write FSM: W_IDLE→W_RESP.
  - In W_IDLE, when s_awvalid & s_wvalid are both high, assert s_awready=s_wready=1 for exactly that cycle and perform the register write.
  - W_RESP holds s_bvalid=1 until s_bready, then returns to W_IDLE. Write latency to bvalid is 1 cycle.
- Read FSM: R_IDLE→R_DATA.
  - In R_IDLE, s_arready=1. On the ar handshake, register s_rdata and assert s_rvalid on the next cycle.
  - R_DATA holds s_rvalid and s_rdata stable until s_rready, then returns to R_IDLE. No new ar is accepted while in R_DATA.
- TX push on a TX2 write:
  - If the TX FIFO is full at the start of the cycle, the packet is dropped and tx_overflow sets.
  - Otherwise the packet is enqueued and visible on fsb_data_o the next cycle. TX0 and TX1 staging registers persist.
- RX pop on the RX2 ar handshake:
  - If empty, rdata=0 and rx_underflow sets.
  - RX0 and RX1 reads on an empty FIFO return 0 without setting any flag.
- FIFOs:
  - Simultaneous push and pop when non-empty and non-full keeps the count unchanged.
  - Full/empty are evaluated on pre-cycle state.
  - Pointers wrap modulo depth.
  - TX_VAC and RX_OCC reflect pre-cycle counts, width clog2(depth)+1.
- STATUS write-1-to-clear: a set event and a clear on the same bit in the same cycle leave the bit set.

Test Plan:
- Reset, then read 0x18 and 0x1C → 16 and 0. STATUS=0, fsb_v_o=0, fsb_ready_o=1.
- Write 0x00=0x11112222, 0x04=0x33334444, 0x08=0x5566 with fsb_ready_i=0 → fsb_v_o=1 and fsb_data_o=80'h5566_33334444_11112222. Raising fsb_ready_i for 1 cycle → fsb_v_o=0.
- Hold fsb_ready_i=0 and perform 17 TX2 writes → TX_VAC=0, STATUS bit0=1. Drain shows exactly 16 packets. Writing 0x20=1 → STATUS=0.
- Drive fsb_v_i with 80'hABCD_01234567_89ABCDEF → RX_OCC=1, RX0=0x89ABCDEF, RX1=0x01234567, RX2=0x0000ABCD, then RX_OCC=0.
- Read RX2 when empty → rdata=0, STATUS bit1=1. Fill RX with 16 packets → fsb_ready_o=0. Popping one → fsb_ready_o=1 the next cycle.
- Hold s_bready=0 and s_rready=0 for 5 cycles → bvalid and rvalid stay high with stable rdata, no extra handshakes. Asserting pipe_rst_n=0 mid-hold → bvalid and rvalid drop asynchronously and FIFOs empty.
